// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_lock;
    logic          dma_gnt;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_ack, cpu_rdata,
        output dma_gnt, dma_ack, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_ack, cpu_rdata,
        input  dma_gnt, dma_ack, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU/DMA single-port memory arbiter: gnt one cycle after req, ack LAT cycles later; one transfer per LAT+2.
// Requesters hold req until ack; fixed CPU priority with bounded DMA lock bursts, round-robin when MEM_ARB_RR_EN.
module mem_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int LAT       = 1,
    parameter int BURST_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus_if
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(LAT - 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d;          // 1 = DMA owns the current access
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          lock_q, lock_d;
    logic [BW-1:0] burst_q, burst_d;
`ifdef MEM_ARB_RR_EN
    logic          last_q, last_d;        // 1 = DMA won the previous grant
`endif
    logic          dma_wins;
    logic          in_access;
    logic          in_resp;

    // Lock/burst exception is evaluated before the plain contention policy.
    always_comb begin
        dma_wins = 1'b0;
        if (bus_if.dma_req && !bus_if.cpu_req) begin
            dma_wins = 1'b1;
        end else if (bus_if.dma_req && bus_if.cpu_req) begin
            if (lock_q && (burst_q < BURST_LIM)) begin
                dma_wins = 1'b1;
            end else begin
`ifdef MEM_ARB_RR_EN
                dma_wins = !last_q;
`else
                dma_wins = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        lock_d      = lock_q;
        burst_d     = burst_q;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!bus_if.dma_req) begin
                    lock_d = 1'b0;
                end
                if (bus_if.cpu_req || bus_if.dma_req) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_INIT;
                    win_d   = dma_wins;
                    we_d    = dma_wins ? bus_if.dma_we    : bus_if.cpu_we;
                    addr_d  = dma_wins ? bus_if.dma_addr  : bus_if.cpu_addr;
                    wdata_d = dma_wins ? bus_if.dma_wdata : bus_if.cpu_wdata;
`ifdef MEM_ARB_RR_EN
                    last_d  = dma_wins;
`endif
                    if (dma_wins) begin
                        lock_d = bus_if.dma_lock;
                        if (lock_q && bus_if.cpu_req && (burst_q < BURST_LIM)) begin
                            burst_d = burst_q + BW'(1);
                        end
                    end else begin
                        lock_d  = 1'b0;
                        burst_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        if (win_q) begin
                            dma_rdata_d = bus_if.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus_if.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            lock_q      <= 1'b0;
            burst_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            lock_q      <= lock_d;
            burst_q     <= burst_d;
`ifdef MEM_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign in_access        = (state_q == S_ACCESS);
    assign in_resp          = (state_q == S_RESP);
    assign bus_if.mem_en    = in_access;
    assign bus_if.mem_we    = in_access && we_q;
    assign bus_if.mem_addr  = in_access ? addr_q  : '0;
    assign bus_if.mem_wdata = in_access ? wdata_q : '0;
    assign bus_if.cpu_gnt   = in_access && (cnt_q == CNT_INIT) && !win_q;
    assign bus_if.dma_gnt   = in_access && (cnt_q == CNT_INIT) &&  win_q;
    assign bus_if.cpu_ack   = in_resp && !win_q;
    assign bus_if.dma_ack   = in_resp &&  win_q;
    assign bus_if.cpu_rdata = cpu_rdata_q;
    assign bus_if.dma_rdata = dma_rdata_q;
    assign bus_if.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiter instances (LAT=1/BURST_MAX=2 and LAT=3) sharing one memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(12), .DW(16)) ifa ();
    mem_port_arbiter_if #(.AW(12), .DW(16)) ifb ();

    mem_port_arbiter #(.AW(12), .DW(16), .LAT(1), .BURST_MAX(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus_if(ifa));
    mem_port_arbiter #(.AW(12), .DW(16), .LAT(3), .BURST_MAX(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus_if(ifb));

    logic [15:0] mem [0:4095];
    bit          mem_ready = 1'b0;
    assign ifa.mem_rdata = mem[ifa.mem_addr];
    assign ifb.mem_rdata = mem[ifb.mem_addr];

    always @(posedge clk) begin
        if (!mem_ready) begin
            mem[12'h005] <= 16'h7A3C;
            mem[12'h010] <= 16'h5A5A;
            mem_ready    <= 1'b1;
        end else if (ifa.mem_en && ifa.mem_we) begin
            mem[ifa.mem_addr] <= ifa.mem_wdata;
        end
    end

    // d: 0=instance A, 1=instance B; p: 0=CPU, 1=DMA; k: 0=gnt, 1=ack
    typedef struct {
        int          cyc;
        int          d;
        int          p;
        int          k;
        logic        we;
        logic [11:0] addr;
        logic [15:0] dat;
    } ev_t;
    ev_t expq[$];

    task automatic ex(input int c, input int d, input int p, input int k,
                      input logic we, input logic [11:0] a, input logic [15:0] dat);
        ev_t e;
        e.cyc = c; e.d = d; e.p = p; e.k = k; e.we = we; e.addr = a; e.dat = dat;
        expq.push_back(e);
    endtask

    task automatic ev_chk(input int d, input int p, input int k, input logic en,
                          input logic bsy, input logic we, input logic [11:0] a,
                          input logic [15:0] wd, input logic [15:0] rd);
        ev_t e;
        bit  ok;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event d%0d p%0d k%0d at cyc=%0d, want none", d, p, k, cyc);
            return;
        end
        e = expq.pop_front();
        ok = (e.cyc == cyc) && (e.d == d) && (e.p == p) && (e.k == k);
        if (k == 0) ok = ok && en && (a == e.addr) && (we == e.we) && (!e.we || wd == e.dat);
        else        ok = ok && !en && bsy && (rd == e.dat);
        if (!ok) begin
            errors++;
            $display("FAIL event: got cyc=%0d d%0d p%0d k%0d en=%b busy=%b we=%b addr=%h wd=%h rd=%h, want cyc=%0d d%0d p%0d k%0d we=%b addr=%h dat=%h",
                     cyc, d, p, k, en, bsy, we, a, wd, rd, e.cyc, e.d, e.p, e.k, e.we, e.addr, e.dat);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.cpu_gnt) ev_chk(0, 0, 0, ifa.mem_en, ifa.busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.cpu_rdata);
        if (ifa.cpu_ack) ev_chk(0, 0, 1, ifa.mem_en, ifa.busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.cpu_rdata);
        if (ifa.dma_gnt) ev_chk(0, 1, 0, ifa.mem_en, ifa.busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.dma_rdata);
        if (ifa.dma_ack) ev_chk(0, 1, 1, ifa.mem_en, ifa.busy, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.dma_rdata);
        if (ifb.cpu_gnt) ev_chk(1, 0, 0, ifb.mem_en, ifb.busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.cpu_rdata);
        if (ifb.cpu_ack) ev_chk(1, 0, 1, ifb.mem_en, ifb.busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.cpu_rdata);
        if (ifb.dma_gnt) ev_chk(1, 1, 0, ifb.mem_en, ifb.busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.dma_rdata);
        if (ifb.dma_ack) ev_chk(1, 1, 1, ifb.mem_en, ifb.busy, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.dma_rdata);
    end

    task automatic chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is seen.
    task automatic cpu_a(input logic we, input logic [11:0] a, input logic [15:0] wd, input bit hold);
        int n = 0;
        ifa.cpu_req = 1'b1; ifa.cpu_we = we; ifa.cpu_addr = a; ifa.cpu_wdata = wd;
        do begin @(negedge clk); n++; end while (!ifa.cpu_ack && n < 60);
        chk_val("cpu_ack_wait", {31'd0, ifa.cpu_ack}, 32'd1);
        if (!hold) ifa.cpu_req = 1'b0;
    endtask

    task automatic dma_a(input logic we, input logic [11:0] a, input logic [15:0] wd,
                         input logic lock, input bit hold);
        int n = 0;
        ifa.dma_req = 1'b1; ifa.dma_we = we; ifa.dma_addr = a; ifa.dma_wdata = wd; ifa.dma_lock = lock;
        do begin @(negedge clk); n++; end while (!ifa.dma_ack && n < 60);
        chk_val("dma_ack_wait", {31'd0, ifa.dma_ack}, 32'd1);
        if (!hold) ifa.dma_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        int n;
        ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = 0; ifa.cpu_wdata = 0;
        ifa.dma_req = 0; ifa.dma_we = 0; ifa.dma_addr = 0; ifa.dma_wdata = 0; ifa.dma_lock = 0;
        ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = 0; ifb.cpu_wdata = 0;
        ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_addr = 0; ifb.dma_wdata = 0; ifb.dma_lock = 0;
        repeat (3) @(negedge clk);

        chk_val("rst_cpu_gnt",   {31'd0, ifa.cpu_gnt}, 32'd0);
        chk_val("rst_cpu_ack",   {31'd0, ifa.cpu_ack}, 32'd0);
        chk_val("rst_cpu_rdata", {16'd0, ifa.cpu_rdata}, 32'd0);
        chk_val("rst_dma_gnt",   {31'd0, ifa.dma_gnt}, 32'd0);
        chk_val("rst_dma_ack",   {31'd0, ifa.dma_ack}, 32'd0);
        chk_val("rst_dma_rdata", {16'd0, ifa.dma_rdata}, 32'd0);
        chk_val("rst_mem_en",    {31'd0, ifa.mem_en}, 32'd0);
        chk_val("rst_mem_we",    {31'd0, ifa.mem_we}, 32'd0);
        chk_val("rst_mem_addr",  {20'd0, ifa.mem_addr}, 32'd0);
        chk_val("rst_mem_wdata", {16'd0, ifa.mem_wdata}, 32'd0);
        chk_val("rst_busy",      {31'd0, ifa.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU read alone
        c = cyc;
        ex(c + 1, 0, 0, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 2, 0, 0, 1, 1'b0, 12'h000, 16'h7A3C);
        cpu_a(1'b0, 12'h005, 16'h0000, 1'b0);
        @(negedge clk);

        // Simultaneous CPU read and DMA write
        c = cyc;
`ifdef MEM_ARB_RR_EN
        ex(c + 1, 0, 1, 0, 1'b1, 12'h020, 16'hBEEF);
        ex(c + 2, 0, 1, 1, 1'b0, 12'h000, 16'h0000);
        ex(c + 4, 0, 0, 0, 1'b0, 12'h010, 16'h0000);
        ex(c + 5, 0, 0, 1, 1'b0, 12'h000, 16'h5A5A);
`else
        ex(c + 1, 0, 0, 0, 1'b0, 12'h010, 16'h0000);
        ex(c + 2, 0, 0, 1, 1'b0, 12'h000, 16'h5A5A);
        ex(c + 4, 0, 1, 0, 1'b1, 12'h020, 16'hBEEF);
        ex(c + 5, 0, 1, 1, 1'b0, 12'h000, 16'h0000);
`endif
        fork
            cpu_a(1'b0, 12'h010, 16'h0000, 1'b0);
            dma_a(1'b1, 12'h020, 16'hBEEF, 1'b0, 1'b0);
        join
        @(negedge clk);

        // Locked DMA burst against a waiting CPU, BURST_MAX=2
        c = cyc;
        ex(c + 1,  0, 1, 0, 1'b1, 12'h100, 16'hD000);
        ex(c + 2,  0, 1, 1, 1'b0, 12'h000, 16'h0000);
        ex(c + 4,  0, 1, 0, 1'b1, 12'h101, 16'hD001);
        ex(c + 5,  0, 1, 1, 1'b0, 12'h000, 16'h0000);
        ex(c + 7,  0, 1, 0, 1'b1, 12'h102, 16'hD002);
        ex(c + 8,  0, 1, 1, 1'b0, 12'h000, 16'h0000);
        ex(c + 10, 0, 0, 0, 1'b0, 12'h020, 16'h0000);
        ex(c + 11, 0, 0, 1, 1'b0, 12'h000, 16'hBEEF);
        ex(c + 13, 0, 1, 0, 1'b0, 12'h100, 16'h0000);
        ex(c + 14, 0, 1, 1, 1'b0, 12'h000, 16'hD000);
        fork
            begin
                dma_a(1'b1, 12'h100, 16'hD000, 1'b1, 1'b1);
                dma_a(1'b1, 12'h101, 16'hD001, 1'b1, 1'b1);
                dma_a(1'b1, 12'h102, 16'hD002, 1'b1, 1'b1);
                dma_a(1'b0, 12'h100, 16'h0000, 1'b1, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                cpu_a(1'b0, 12'h020, 16'h0000, 1'b0);
            end
        join
        @(negedge clk);

        // CPU write then read back; the write ack leaves cpu_rdata alone
        c = cyc;
        ex(c + 1, 0, 0, 0, 1'b1, 12'h0FF, 16'h1234);
        ex(c + 2, 0, 0, 1, 1'b0, 12'h000, 16'hBEEF);
        cpu_a(1'b1, 12'h0FF, 16'h1234, 1'b0);
        @(negedge clk);
        c = cyc;
        ex(c + 1, 0, 0, 0, 1'b0, 12'h0FF, 16'h0000);
        ex(c + 2, 0, 0, 1, 1'b0, 12'h000, 16'h1234);
        cpu_a(1'b0, 12'h0FF, 16'h0000, 1'b0);
        @(negedge clk);

        // Both requesting back-to-back without lock
        c = cyc;
`ifdef MEM_ARB_RR_EN
        ex(c + 1,  0, 1, 0, 1'b0, 12'h010, 16'h0000);
        ex(c + 2,  0, 1, 1, 1'b0, 12'h000, 16'h5A5A);
        ex(c + 4,  0, 0, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 5,  0, 0, 1, 1'b0, 12'h000, 16'h7A3C);
        ex(c + 7,  0, 1, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 8,  0, 1, 1, 1'b0, 12'h000, 16'h7A3C);
        ex(c + 10, 0, 0, 0, 1'b0, 12'h0FF, 16'h0000);
        ex(c + 11, 0, 0, 1, 1'b0, 12'h000, 16'h1234);
`else
        ex(c + 1,  0, 0, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 2,  0, 0, 1, 1'b0, 12'h000, 16'h7A3C);
        ex(c + 4,  0, 0, 0, 1'b0, 12'h0FF, 16'h0000);
        ex(c + 5,  0, 0, 1, 1'b0, 12'h000, 16'h1234);
        ex(c + 7,  0, 1, 0, 1'b0, 12'h010, 16'h0000);
        ex(c + 8,  0, 1, 1, 1'b0, 12'h000, 16'h5A5A);
        ex(c + 10, 0, 1, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 11, 0, 1, 1, 1'b0, 12'h000, 16'h7A3C);
`endif
        fork
            begin
                cpu_a(1'b0, 12'h005, 16'h0000, 1'b1);
                cpu_a(1'b0, 12'h0FF, 16'h0000, 1'b0);
            end
            begin
                dma_a(1'b0, 12'h010, 16'h0000, 1'b0, 1'b1);
                dma_a(1'b0, 12'h005, 16'h0000, 1'b0, 1'b0);
            end
        join
        @(negedge clk);

        // LAT=3 instance: reset in the second ACCESS cycle abandons the access
        c = cyc;
        ex(c + 1, 1, 0, 0, 1'b0, 12'h005, 16'h0000);
        ifb.cpu_req = 1'b1; ifb.cpu_we = 1'b0; ifb.cpu_addr = 12'h005;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("midrst_cpu_gnt",   {31'd0, ifb.cpu_gnt}, 32'd0);
        chk_val("midrst_cpu_ack",   {31'd0, ifb.cpu_ack}, 32'd0);
        chk_val("midrst_cpu_rdata", {16'd0, ifb.cpu_rdata}, 32'd0);
        chk_val("midrst_mem_en",    {31'd0, ifb.mem_en}, 32'd0);
        chk_val("midrst_mem_addr",  {20'd0, ifb.mem_addr}, 32'd0);
        chk_val("midrst_busy",      {31'd0, ifb.busy}, 32'd0);
        ifb.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        c = cyc;
        ex(c + 1, 1, 0, 0, 1'b0, 12'h005, 16'h0000);
        ex(c + 4, 1, 0, 1, 1'b0, 12'h000, 16'h7A3C);
        ifb.cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifb.cpu_ack && n < 60);
        chk_val("b_cpu_ack_wait", {31'd0, ifb.cpu_ack}, 32'd1);
        ifb.cpu_req = 1'b0;
        repeat (3) @(negedge clk);

        chk_val("pending_events", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the CPU controller (fetch, indirect and execute memory cycles) and a DMA requester.
- Sits between both requesters and the memory model.
- Serialises accesses through a latched request, a fixed-latency access phase and a one-cycle response pulse.
- Supports DMA burst locking with a bounded burst length, so CPU fetch is never starved.

Parameters:
- AW, 12, address width (matches AR).
- DW, 16, data width.
- LAT, 1, memory access cycles per transfer (>=1).
- BURST_MAX, 4, maximum consecutive locked DMA grants while the CPU is waiting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access started.
- cpu_ack  out  1  one-cycle pulse: CPU access complete.
- cpu_rdata  out  DW  CPU read data, valid from cpu_ack.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request; same rules as CPU.
- dma_lock  in  1  burst hint, sampled at DMA win.
- dma_gnt, dma_ack  out  1  DMA pulses; same rules as CPU.
- dma_rdata  out  DW  DMA read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid on the last access cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: async, active-low. Effects:
  - FSM to IDLE.
  - All outputs 0, including both rdata registers.
  - Burst counter 0, lock flag 0, last_winner = DMA.
  - Reset mid-access abandons the access: no ack is issued and no further mem_en.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we/addr/wdata and ID.
  - Load access counter with LAT-1.
  - Go to ACCESS.
  - The arbitration decision uses req values in this cycle only.
- ACCESS:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched copy.
  - Winner's gnt=1 on the first ACCESS cycle only.
  - Counter decrements each cycle; on count 0, capture mem_rdata (reads only) into the winner's rdata register and go to RESP.
  - Requester input changes during ACCESS are ignored.
- RESP:
  - Winner's ack=1 for exactly one cycle; mem_en=0.
  - Go to IDLE; no arbitration in this cycle.
- Latency:
  - req high in IDLE at cycle n -> gnt at n+1 -> ack at n+1+LAT.
  - Throughput: one transfer per LAT+2 cycles.
- Writes: ack is still issued; that port's rdata is unchanged.
- Priority, default (fixed):
  - CPU beats DMA when both request.
  - Exception: lock flag set, dma_req high and burst counter < BURST_MAX -> DMA wins.
- Lock and burst counter:
  - Lock flag := dma_lock, sampled when DMA wins.
  - Lock flag is cleared when CPU wins or when dma_req is low in IDLE.
  - Burst counter increments on each locked DMA win while cpu_req is high.
  - Burst counter resets to 0 on any CPU win.
  - Counter saturates at BURST_MAX; at saturation the CPU wins the next arbitration.
- Single requester: it always wins, regardless of lock or counter.
- Protocol violation: req dropped after gnt but before ack -> access still completes and ack is still pulsed.
- rdata registers hold their value until that port's next read completes.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: unlocked contention (both req, lock inactive or burst saturated) is round-robin.
  - The requester that is not last_winner wins.
  - last_winner updates on every grant.
  - The lock/BURST_MAX rules still apply first.
- Undefined: fixed CPU priority as above; last_winner logic is not compiled.

Test Plan:
- LAT=1, CPU read 0x005, memory holds 0x7A3C:
  - cpu_gnt is high 1 cycle after req; mem_en high for 1 cycle with mem_addr=0x005.
  - cpu_ack is high 2 cycles after req with cpu_rdata=0x7A3C.
  - dma_gnt and dma_ack stay 0 throughout.
- Simultaneous CPU read 0x010 and DMA write 0x020=0xBEEF, no lock, macro off:
  - CPU granted first, ack at +2.
  - DMA granted at +4, mem_we=1 with mem_wdata=0xBEEF, dma_ack at +5.
- BURST_MAX=2, DMA with dma_lock=1 holding 4 back-to-back requests, CPU requesting from the second DMA grant onward:
  - Grant order is DMA, DMA, DMA, CPU, DMA.
  - The first DMA grant does not count, because the CPU is not waiting then.
- LAT=3: assert rst_n=0 in the second ACCESS cycle:
  - All outputs drop to 0 immediately; no ack ever appears; busy=0.
  - A new CPU request after reset is served normally.
- MEM_ARB_RR_EN defined, both requesters continuously requesting, no lock:
  - Grants alternate CPU, DMA, CPU, DMA.
  - Each grant is LAT+2 cycles apart.
- Write 0x1234 to 0x0FF via CPU, then CPU read 0x0FF:
  - Read ack returns cpu_rdata=0x1234.
  - cpu_rdata is unchanged by the write's ack.
